// File: rtl/array_port_serializer_pkg.sv
// Shared types and constants for the array port serializer and its array interface.
package array_port_serializer_pkg;

  localparam int unsigned ARRAY_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/array_port_serializer_if.sv
// Interface carrying an unpacked array of 1-bit elements; P drives it, C only reads it.
interface I #(
  parameter int unsigned N = array_port_serializer_pkg::ARRAY_LEN
) ();

  logic x [N-1:0];

  modport P (output x);
  modport C (input x);

endinterface

// File: rtl/array_port_serializer.sv
// Snapshots an unpacked array from interface I and streams it out one element per
// accepted transfer, lowest index first, with a valid/ready handshake and a done pulse.
module array_port_serializer
  import array_port_serializer_pkg::*;
#(
  parameter int unsigned N = ARRAY_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  I.C          j,
  input  logic i_start,
  input  logic i_ready,
  output logic o_data,
  output logic o_valid,
  output logic o_last,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [N-1:0]     r_shadow;
  logic [N-1:0]     w_shadow_nxt;
  logic [N-1:0]     w_snap;

  logic r_data;
  logic r_valid;
  logic r_last;
  logic r_busy;
  logic r_done;

  logic w_data_nxt;
  logic w_valid_nxt;
  logic w_last_nxt;
  logic w_busy_nxt;
  logic w_done_nxt;

  // Flatten the interface array so the snapshot is a single vector load.
  always_comb begin
    w_snap = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_snap[k] = j.x[k];
    end
  end

  // Next-state logic; outputs are precomputed from next state so they leave a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_shadow_nxt = w_snap;
          w_idx_nxt    = '0;
          w_state_nxt  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_valid_nxt = (w_state_nxt == ST_SEND);
    w_data_nxt  = w_valid_nxt & w_shadow_nxt[w_idx_nxt];
    w_last_nxt  = w_valid_nxt & (w_idx_nxt == LAST_IDX);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
  end

  // State, counter, shadow and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
      r_data   <= 1'b0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_last   <= w_last_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_array_port_serializer.sv
// Self-checking bench: queue-based frame model checked every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_array_port_serializer;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;
  logic start;
  logic ready;
  logic o_data;
  logic o_valid;
  logic o_last;
  logic o_busy;
  logic o_done;

  I #(.N(N)) j_if ();

  array_port_serializer #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .j       (j_if),
    .i_start (start),
    .i_ready (ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: remaining elements of the current frame, plus a pending done cycle.
  bit m_q[$];
  bit m_done = 1'b0;
  // Elements actually accepted from the DUT.
  bit rx[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input logic [N-1:0] v);
    for (int k = 0; k < int'(N); k++) j_if.x[k] = v[k];
  endtask

  task automatic chk_rx(input string nm, input logic [N-1:0] exp);
    logic [N-1:0] got;
    got = '0;
    for (int i = 0; i < rx.size() && i < int'(N); i++) got[i] = rx[i];
    chk({nm, "_count"}, 32'(rx.size()), 32'(N));
    chk({nm, "_bits"}, 32'(got), 32'(exp));
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_q.size() != 0) begin
      if (ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end else if (start) begin
      for (int k = 0; k < int'(N); k++) m_q.push_back(j_if.x[k]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(o_valid), 32'(m_q.size() != 0));
      chk("busy", 32'(o_busy), 32'((m_q.size() != 0) || m_done));
      chk("done", 32'(o_done), 32'(m_done));
      if (m_q.size() != 0) begin
        chk("data", 32'(o_data), 32'(m_q[0]));
        chk("last", 32'(o_last), 32'(m_q.size() == 1));
      end
      if (o_valid && ready) rx.push_back(o_data);
    end
  end

  logic [N-1:0] cap;
  logic [N-1:0] lst;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    set_x('0);
    repeat (2) tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    rst = 1'b0;
    tick();

    // Scenario 1: plain frame, ready held high.
    set_x(8'b1010_0110);
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      @(negedge clk);
      cap[k] = o_data;
      lst[k] = o_last;
      tick();
    end
    @(negedge clk);
    chk("s1_done_t9", 32'(o_done), 32'd1);
    chk("s1_valid_t9", 32'(o_valid), 32'd0);
    chk("s1_order", 32'(cap), 32'h0000_00a6);
    chk("s1_last_pos", 32'(lst), 32'h0000_0080);
    tick();

    // Scenario 2: ready toggling 1,0,0,1,...
    rx.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
    end
    ready = 1'b1;
    chk_rx("s2_rx", 8'b1010_0110);

    // Scenario 3: array changes right after the snapshot.
    rx.delete();
    set_x(8'b0011_1001);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_x(8'hff);
    repeat (12) tick();
    chk_rx("s3_rx", 8'b0011_1001);

    // Scenario 4: start pulsed while element 3 is on the bus.
    rx.delete();
    set_x(8'b1101_0010);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("s4_busy_t9", 32'(o_busy), 32'd1);
    chk("s4_done_t9", 32'(o_done), 32'd1);
    tick();
    @(negedge clk);
    chk("s4_busy_t10", 32'(o_busy), 32'd0);
    repeat (10) tick();
    chk_rx("s4_rx", 8'b1101_0010);

    // Scenario 5: reset while element 4 is on the bus.
    rx.delete();
    set_x(8'b0110_1100);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("s5_valid", 32'(o_valid), 32'd0);
    chk("s5_busy", 32'(o_busy), 32'd0);
    chk("s5_data", 32'(o_data), 32'd0);
    chk("s5_last", 32'(o_last), 32'd0);
    chk("s5_done", 32'(o_done), 32'd0);
    tick();
    @(negedge clk);
    chk("s5_no_done", 32'(o_done), 32'd0);
    rx.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk_rx("s5_rx", 8'b0110_1100);

    // Scenario 6: reset and start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("s6_valid", 32'(o_valid), 32'd0);
    chk("s6_busy", 32'(o_busy), 32'd0);
    tick();
    @(negedge clk);
    chk("s6_valid2", 32'(o_valid), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_x(N'($urandom));
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst   = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
